// File: rtl/eim_burst_regfile.sv
// eim_burst_regfile: CPU-facing register file on the multiplexed EIM bus.
// Pins are synchronised into the clk domain. A three-state transaction
// machine captures a burst start address and auto-increments it on every
// beat. Each beat prefetches the next read value and stalls the CPU with
// eim_wait_n while the prefetch completes.
module eim_burst_regfile #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int DEPTH       = 8,
  parameter int RW_DEPTH    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                eim_cs_n,
  input  logic                                eim_lba_n,
  input  logic                                eim_wr_n,
  input  logic                                eim_oe_n,
  input  logic [DATA_W-1:0]                   da_in,
  output logic [DATA_W-1:0]                   da_out,
  output logic                                da_oe,
  output logic                                eim_wait_n,
  input  logic [(DEPTH-RW_DEPTH)*DATA_W-1:0]  ro_in,
  output logic [RW_DEPTH*DATA_W-1:0]          regs_out,
  output logic                                wr_strobe,
  output logic [ADDR_W-1:0]                   wr_addr,
  output logic [7:0]                          err_cnt
);

  localparam int RO_DEPTH = DEPTH - RW_DEPTH;
  localparam int SPAN     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] RW_LIM = (ADDR_W + 1)'(RW_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_r, lba_sync_r, wr_sync_r, oe_sync_r;
  logic [DATA_W-1:0]      da_pipe_r [SYNC_STAGES];
  logic                   cs_d_r, lba_d_r, wr_d_r, oe_d_r;

  logic                   cs_s, lba_s, wr_s, oe_s;
  logic [DATA_W-1:0]      da_s;
  logic                   cs_rise_s, lba_fall_s, lba_rise_s, wr_rise_s, oe_rise_s;

  state_t                 state_r, state_nxt_s;
  logic [ADDR_W-1:0]      addr_r, addr_nxt_s;
  logic                   trig_s, wr_ok_s, drop_s, addr_in_rw_s;
  logic                   pend_r;
  logic [DATA_W-1:0]      regs_r [RW_DEPTH];
  logic [DATA_W-1:0]      rd_tab_s [SPAN];
  logic [DATA_W-1:0]      rd_data_s;

  // Pad drive follows the pins directly so bus turnaround is not delayed.
  assign da_oe = ~eim_oe_n & ~eim_cs_n;

  // Control synchronisers idle high so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_r  <= '1;
      lba_sync_r <= '1;
      wr_sync_r  <= '1;
      oe_sync_r  <= '1;
    end else begin
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0],  eim_cs_n};
      lba_sync_r <= {lba_sync_r[SYNC_STAGES-2:0], eim_lba_n};
      wr_sync_r  <= {wr_sync_r[SYNC_STAGES-2:0],  eim_wr_n};
      oe_sync_r  <= {oe_sync_r[SYNC_STAGES-2:0],  eim_oe_n};
    end
  end

  // Data pipeline of equal depth keeps bus data aligned with the controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) da_pipe_r[i] <= '0;
    end else begin
      da_pipe_r[0] <= da_in;
      for (int i = 1; i < SYNC_STAGES; i++) da_pipe_r[i] <= da_pipe_r[i-1];
    end
  end

  assign cs_s  = cs_sync_r[SYNC_STAGES-1];
  assign lba_s = lba_sync_r[SYNC_STAGES-1];
  assign wr_s  = wr_sync_r[SYNC_STAGES-1];
  assign oe_s  = oe_sync_r[SYNC_STAGES-1];
  assign da_s  = da_pipe_r[SYNC_STAGES-1];

  // One-cycle-delayed copies of the synced controls for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_d_r  <= 1'b1;
      lba_d_r <= 1'b1;
      wr_d_r  <= 1'b1;
      oe_d_r  <= 1'b1;
    end else begin
      cs_d_r  <= cs_s;
      lba_d_r <= lba_s;
      wr_d_r  <= wr_s;
      oe_d_r  <= oe_s;
    end
  end

  assign cs_rise_s    = cs_s & ~cs_d_r;
  assign lba_fall_s   = ~lba_s & lba_d_r;
  assign lba_rise_s   = lba_s & ~lba_d_r;
  assign wr_rise_s    = wr_s & ~wr_d_r;
  assign oe_rise_s    = oe_s & ~oe_d_r;
  assign addr_in_rw_s = ({1'b0, addr_r} < RW_LIM);

  // Transaction decode: next state, address update, write/drop and prefetch trigger.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    trig_s      = 1'b0;
    wr_ok_s     = 1'b0;
    drop_s      = 1'b0;
    if (cs_rise_s) begin
      state_nxt_s = ST_IDLE;
    end else if (!cs_s) begin
      if (lba_fall_s) begin
        // Address capture wins; a write arriving in the same cycle is lost.
        state_nxt_s = ST_ADDR;
        addr_nxt_s  = da_s[ADDR_W-1:0];
        drop_s      = (state_r == ST_DATA) & wr_rise_s;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_nxt_s = ST_IDLE;
          end
          ST_ADDR: begin
            if (lba_rise_s) begin
              state_nxt_s = ST_DATA;
              trig_s      = 1'b1;
            end else begin
              state_nxt_s = ST_ADDR;
            end
          end
          ST_DATA: begin
            if (wr_rise_s) begin
              // A coincident oe rise is absorbed: one beat, one increment.
              wr_ok_s    = addr_in_rw_s;
              drop_s     = ~addr_in_rw_s;
              addr_nxt_s = addr_r + ADDR_W'(1);
              trig_s     = 1'b1;
            end else if (oe_rise_s) begin
              addr_nxt_s = addr_r + ADDR_W'(1);
              trig_s     = 1'b1;
            end else begin
              state_nxt_s = ST_DATA;
            end
          end
          default: begin
            state_nxt_s = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  // CPU-writable register array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RW_DEPTH; i++) regs_r[i] <= '0;
    end else begin
      for (int i = 0; i < RW_DEPTH; i++) begin
        if (wr_ok_s && (addr_r == ADDR_W'(i))) regs_r[i] <= da_s;
      end
    end
  end

  // Read map over the whole address space: RW registers, status inputs, then zero.
  always_comb begin
    for (int i = 0; i < SPAN; i++)     rd_tab_s[i] = '0;
    for (int i = 0; i < RW_DEPTH; i++) rd_tab_s[i] = regs_r[i];
    for (int i = 0; i < RO_DEPTH; i++) rd_tab_s[RW_DEPTH + i] = ro_in[i*DATA_W +: DATA_W];
    rd_data_s = rd_tab_s[addr_r];
  end

  // Prefetch: load da_out the cycle after a trigger and hold wait low across both cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r     <= 1'b0;
      da_out     <= '0;
      eim_wait_n <= 1'b1;
    end else begin
      pend_r     <= trig_s;
      eim_wait_n <= ~(trig_s | pend_r);
      if (pend_r) begin
        da_out <= rd_data_s;
      end else begin
        da_out <= da_out;
      end
    end
  end

  // Fabric write strobe and the address it refers to.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= wr_ok_s;
      if (wr_ok_s) begin
        wr_addr <= addr_r;
      end else begin
        wr_addr <= wr_addr;
      end
    end
  end

  // Saturating count of writes that could not land in a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (drop_s && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end

  for (genvar g = 0; g < RW_DEPTH; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs_r[g];
  end

endmodule

// File: tb/tb_eim_burst_regfile.sv
// Scoreboard bench for eim_burst_regfile with default parameters.
// Expected writes and prefetch values are queued as stimulus is driven, then
// popped when the DUT strobes a write or a beat samples da_out.
module tb_eim_burst_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        eim_cs_n, eim_lba_n, eim_wr_n, eim_oe_n;
  logic [7:0]  da_in;
  logic [7:0]  da_out;
  logic        da_oe, eim_wait_n;
  logic [15:0] ro_in;
  logic [47:0] regs_out;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         strobe_cnt = 0;
  int         exp_strobes = 0;
  int         exp_err = 0;
  logic [7:0] model_regs [6];
  logic [2:0] model_addr;
  wr_t        wr_q [$];
  logic [7:0] rd_q [$];
  wr_t        wr_e;

  eim_burst_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .eim_cs_n   (eim_cs_n),
    .eim_lba_n  (eim_lba_n),
    .eim_wr_n   (eim_wr_n),
    .eim_oe_n   (eim_oe_n),
    .da_in      (da_in),
    .da_out     (da_out),
    .da_oe      (da_oe),
    .eim_wait_n (eim_wait_n),
    .ro_in      (ro_in),
    .regs_out   (regs_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
    if (a < 3'd6) return model_regs[a];
    else if (a == 3'd6) return 8'hEF;
    else return 8'hBE;
  endfunction

  function automatic logic [47:0] model_flat();
    logic [47:0] f;
    for (int i = 0; i < 6; i++) f[i*8 +: 8] = model_regs[i];
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pop_rd(input string tag);
    if (rd_q.size() > 0) check_eq(tag, {56'd0, da_out}, {56'd0, rd_q.pop_front()});
  endtask

  task automatic cs_low();
    eim_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    pop_rd("pref_end");
    eim_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic addr_phase(input logic [2:0] a);
    int lo;
    lo = 0;
    da_in = {5'd0, a};
    eim_lba_n = 1'b0;
    tick(4);
    eim_lba_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (eim_wait_n == 1'b0) lo++;
    end
    check_eq("wait_lo_cycles", 64'(lo), 64'd2);
    model_addr = a;
    rd_q.push_back(model_read(a));
  endtask

  task automatic write_beat(input logic [7:0] d);
    wr_t e;
    pop_rd("pref_wr");
    da_in = d;
    eim_wr_n = 1'b0;
    tick(4);
    if (model_addr < 3'd6) begin
      model_regs[model_addr] = d;
      e.a = model_addr;
      e.d = d;
      wr_q.push_back(e);
      exp_strobes++;
    end else begin
      exp_err++;
    end
    eim_wr_n = 1'b1;
    tick(6);
    model_addr = model_addr + 3'd1;
    rd_q.push_back(model_read(model_addr));
  endtask

  task automatic read_beat();
    pop_rd("rd_beat");
    eim_oe_n = 1'b0;
    tick(3);
    check_eq("da_oe_on", {63'd0, da_oe}, 64'd1);
    tick(1);
    eim_oe_n = 1'b1;
    tick(6);
    model_addr = model_addr + 3'd1;
    rd_q.push_back(model_read(model_addr));
  endtask

  task automatic check_totals(input string tag);
    check_eq({tag, "_regs"}, {16'd0, regs_out}, {16'd0, model_flat()});
    check_eq({tag, "_err"}, {56'd0, err_cnt}, 64'(exp_err));
    check_eq({tag, "_strobes"}, 64'(strobe_cnt), 64'(exp_strobes));
  endtask

  // Write strobe monitor: each strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      if (wr_q.size() == 0) begin
        check_eq("unexp_strobe", {63'd0, wr_strobe}, 64'd0);
      end else begin
        wr_e = wr_q.pop_front();
        check_eq("wr_addr", {61'd0, wr_addr}, {61'd0, wr_e.a});
        check_eq("wr_data", {56'd0, regs_out[wr_e.a*8 +: 8]}, {56'd0, wr_e.d});
      end
    end
  end

  initial begin
    rst = 1'b1;
    eim_cs_n = 1'b1; eim_lba_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
    da_in = 8'h00;
    ro_in = {8'hBE, 8'hEF};
    for (int i = 0; i < 6; i++) model_regs[i] = 8'h00;
    model_addr = 3'd0;
    tick(4);
    rst = 1'b0;
    tick(2);

    // Reset state
    check_eq("rst_regs", {16'd0, regs_out}, 64'd0);
    check_eq("rst_da_out", {56'd0, da_out}, 64'd0);
    check_eq("rst_wait_n", {63'd0, eim_wait_n}, 64'd1);
    check_eq("rst_strobe", {63'd0, wr_strobe}, 64'd0);
    check_eq("rst_wr_addr", {61'd0, wr_addr}, 64'd0);
    check_eq("rst_err", {56'd0, err_cnt}, 64'd0);

    // Single write of 0xA5 to address 2
    cs_low();
    addr_phase(3'd2);
    write_beat(8'hA5);
    cs_high();
    check_eq("single_reg2", {56'd0, regs_out[23:16]}, 64'hA5);
    check_totals("single");

    // Burst write from 4: two land, two are dropped in the status region
    cs_low();
    addr_phase(3'd4);
    write_beat(8'h11);
    write_beat(8'h22);
    write_beat(8'h33);
    write_beat(8'h44);
    cs_high();
    check_eq("burst_err2", {56'd0, err_cnt}, 64'd2);
    check_totals("burst_wr");

    // Burst read from 5 across RW register and both status slices
    cs_low();
    addr_phase(3'd5);
    write_beat(8'h5A);
    cs_high();
    cs_low();
    addr_phase(3'd5);
    read_beat();
    read_beat();
    read_beat();
    cs_high();

    // Address wrap: 7 then 0
    cs_low();
    addr_phase(3'd7);
    read_beat();
    read_beat();
    cs_high();
    check_totals("reads");

    // Chip select high: controls toggle but nothing may happen
    da_in = 8'h03;
    eim_lba_n = 1'b0; tick(4);
    eim_lba_n = 1'b1; tick(4);
    da_in = 8'hFF;
    eim_wr_n = 1'b0; tick(4);
    eim_wr_n = 1'b1;
    eim_oe_n = 1'b0; tick(3);
    check_eq("cs_hi_da_oe", {63'd0, da_oe}, 64'd0);
    eim_oe_n = 1'b1; tick(6);
    check_totals("cs_hi");

    // Reset between address phase and write rise aborts the write
    cs_low();
    addr_phase(3'd1);
    da_in = 8'h77;
    eim_wr_n = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    eim_wr_n = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) model_regs[i] = 8'h00;
    rd_q.delete();
    exp_err = 0;
    tick(6);
    check_eq("abort_da_out", {56'd0, da_out}, 64'd0);
    check_eq("abort_wait_n", {63'd0, eim_wait_n}, 64'd1);
    check_eq("abort_wr_addr", {61'd0, wr_addr}, 64'd0);
    check_totals("abort");
    addr_phase(3'd0);
    write_beat(8'h3C);
    cs_high();
    check_eq("post_rst_reg0", {56'd0, regs_out[7:0]}, 64'h3C);
    check_totals("post_rst");

    check_eq("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/eim_burst_regfile.md
Name: eim_burst_regfile

Overview:
- Parametrised successor to the single-beat EIM proof-of-concept slave: a CPU-facing register file on the multiplexed EIM address/data bus.
- Sits between the top-level pad buffers (tristate stays at top level) and fabric logic.
- Adds input synchronisers, a transaction state machine, auto-incrementing burst access, a read-only status region, a wait_n prefetch stall, a fabric write strobe and a dropped-write counter.

Parameters:
DATA_W, 8, width of the EIM data bus and of each register
ADDR_W, 3, address bits taken from da_in[ADDR_W-1:0] at the address phase
DEPTH, 8, implemented addresses 0..DEPTH-1; must satisfy DEPTH <= 2**ADDR_W
RW_DEPTH, 6, CPU-writable registers at 0..RW_DEPTH-1; read-only registers occupy RW_DEPTH..DEPTH-1; must satisfy 1 <= RW_DEPTH < DEPTH
SYNC_STAGES, 2, synchroniser depth on all EIM inputs; minimum 2

Ports:
clk  in  1  system clock; one clock, all logic on its rising edge
rst  in  1  synchronous reset, active-high
eim_cs_n  in  1  chip select, asynchronous pin
eim_lba_n  in  1  latch-address strobe, asynchronous pin
eim_wr_n  in  1  write enable, asynchronous pin
eim_oe_n  in  1  output enable, asynchronous pin
da_in  in  DATA_W  bus value from pad buffers
da_out  out  DATA_W  registered read data to pad buffers
da_oe  out  1  pad drive enable
eim_wait_n  out  1  wait to CPU, active low, registered
ro_in  in  (DEPTH-RW_DEPTH)*DATA_W  status values; slice k is read at address RW_DEPTH+k
regs_out  out  RW_DEPTH*DATA_W  flattened RW registers; slice i is register i
wr_strobe  out  1  one-cycle pulse on each accepted CPU write
wr_addr  out  ADDR_W  address of that write, valid with wr_strobe
err_cnt  out  8  saturating count of dropped writes

Behaviour:
- Synchronisers:
  - cs_n, lba_n, wr_n and oe_n each pass through SYNC_STAGES flops.
  - da_in passes through an equal-depth pipeline so data stays aligned with the controls.
  - Control sync flops reset to 1 (inactive).
  - Edges are detected on the last stage against a one-cycle-delayed copy.
- da_oe = ~eim_oe_n & ~eim_cs_n. This is combinational from the pins, for turnaround speed; it is the only unregistered output.
- State machine (IDLE, ADDR, DATA). All transitions require synced cs_n low except where noted.
  - Any state: lba fall -> ADDR; addr <= synced da[ADDR_W-1:0].
  - ADDR + lba rise -> DATA; start prefetch.
  - Synced cs_n rising edge -> IDLE from any state, regardless of the cs_n precondition; addr is unchanged.
  - wr/oe edges are acted on only in DATA; in IDLE or ADDR they are ignored.
- Prefetch:
  - The cycle after the trigger, da_out <= read(addr).
  - eim_wait_n = 0 during the trigger cycle and the following cycle, and 1 otherwise.
  - Pin lba rise to valid da_out: SYNC_STAGES+2 cycles.
- read(a):
  - a < RW_DEPTH: the register.
  - RW_DEPTH <= a < DEPTH: ro_in slice.
  - a >= DEPTH: 0.
- Write (DATA + wr rising edge):
  - If addr < RW_DEPTH: reg[addr] <= synced da; wr_strobe = 1 and wr_addr = addr in the next cycle.
  - Otherwise the write is dropped and err_cnt increments.
  - In all cases addr <= addr+1, wrapping modulo 2**ADDR_W, and a prefetch is triggered.
- Read beat end (DATA + oe rising edge): addr <= addr+1 (wraps), and a prefetch is triggered.
- Simultaneous events:
  - lba fall in the same cycle as a wr rise: the address capture wins, the write is dropped and err_cnt increments.
  - wr rise together with oe rise: one write plus a single increment.
- err_cnt saturates at 255.
- Reset: all registers 0, da_out 0, addr 0, state IDLE, eim_wait_n 1, wr_strobe 0, wr_addr 0, err_cnt 0. Reset mid-burst aborts the burst with no write and no strobe; because sync flops reset to inactive, no spurious edges appear after reset release.

Test Plan:
- Single write 0xA5 to addr 2 (cs low, lba pulse with da=2, wr pulse with da=0xA5) -> regs_out[23:16]=0xA5; wr_strobe pulses once with wr_addr=2; err_cnt=0.
- Burst write addr 4 with 0x11,0x22,0x33,0x44 (DEPTH=8, RW_DEPTH=6) -> reg4=0x11, reg5=0x22; addr 6/7 writes dropped; err_cnt=2; exactly 2 wr_strobes.
- Burst read from addr 5 with ro_in={0xBE,0xEF}, reg5=0x5A, three oe pulses -> da_out sequence 0x5A, 0xEF (addr 6), 0xBE (addr 7); eim_wait_n low 2 cycles after lba rise.
- Wrap: ADDR_W=3, DEPTH=8; burst read from addr 7 -> beats return addr 7 then addr 0.
- cs_n high throughout with lba/wr/oe toggling -> no register change, no wr_strobe, da_oe=0, err_cnt=0.
- rst asserted between lba rise and wr rise of a write -> no write, outputs at reset values; the next normal write to addr 0 succeeds.
